// File: rtl/tl_ctrl_param_if.sv
// Signal bundle between the tick/sensor side and the traffic-light controller.
// master drives timing strobe and sensors; slave (the controller) drives lamps and phase.
interface tl_ctrl_param_if #(
    parameter int CNT_W = 4
);
    logic             tick;
    logic             Ta;
    logic             Tb;
    logic             flash;
    logic [1:0]       La;
    logic [1:0]       Lb;
    logic [2:0]       phase;
    logic [CNT_W-1:0] phase_cnt;

    modport master (
        output tick, Ta, Tb, flash,
        input  La, Lb, phase, phase_cnt
    );

    modport slave (
        input  tick, Ta, Tb, flash,
        output La, Lb, phase, phase_cnt
    );
endinterface

// File: rtl/tl_ctrl_param.sv
// Two-road traffic-light controller: tick-timed Moore FSM with min/max green,
// yellow and all-red clearance intervals, and a flashing night mode.
module tl_ctrl_param #(
    parameter int GREEN_MIN = 3,
    parameter int GREEN_MAX = 6,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    tl_ctrl_param_if.slave   bus
);

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        AR_AB = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        AR_BA = 3'd5,
        FLASH = 3'd6
    } state_t;

    localparam logic [1:0] LAMP_GRN = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_RED = 2'b10;
    localparam logic [1:0] LAMP_OFF = 2'b11;

    // Last counter value of each interval; an all-red of 0 ticks exits on its first tick.
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'((ALLRED_T > 0) ? ALLRED_T - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             blink_reg, blink_next;
    state_t           target;
    logic             illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= AR_BA;
            cnt_reg   <= '0;
            blink_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            blink_reg <= blink_next;
        end
    end

    always_comb begin
        target     = state_reg;
        illegal    = 1'b0;
        state_next = state_reg;
        cnt_next   = cnt_reg;
        blink_next = blink_reg;

        case (state_reg)
            A_GRN: if ((cnt_reg >= GMIN_LAST && !bus.Ta) || cnt_reg >= GMAX_LAST) target = A_YEL;
            B_GRN: if ((cnt_reg >= GMIN_LAST && !bus.Tb) || cnt_reg >= GMAX_LAST) target = B_YEL;
            A_YEL: if (cnt_reg == YEL_LAST)
                       target = bus.flash ? FLASH : ((ALLRED_T > 0) ? AR_AB : B_GRN);
            B_YEL: if (cnt_reg == YEL_LAST)
                       target = bus.flash ? FLASH : ((ALLRED_T > 0) ? AR_BA : A_GRN);
            AR_AB: if (bus.flash) target = FLASH;
                   else if (cnt_reg >= AR_LAST) target = B_GRN;
            AR_BA: if (bus.flash) target = FLASH;
                   else if (cnt_reg >= AR_LAST) target = A_GRN;
            FLASH: if (!bus.flash) target = AR_BA;
            default: illegal = 1'b1;
        endcase

        // The undefined code recovers on the next clock whether or not a tick arrives.
        if (illegal) begin
            state_next = AR_BA;
            cnt_next   = '0;
        end else if (bus.tick) begin
            if (target != state_reg) begin
                state_next = target;
                cnt_next   = '0;
                if (target == FLASH) blink_next = 1'b1;
            end else begin
                // Only FLASH can dwell long enough to reach the top; hold there rather than wrap.
                if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
                if (state_reg == FLASH) blink_next = ~blink_reg;
            end
        end
    end

    always_comb begin
        bus.La = LAMP_RED;
        bus.Lb = LAMP_RED;
        case (state_reg)
            A_GRN: bus.La = LAMP_GRN;
            A_YEL: bus.La = LAMP_YEL;
            B_GRN: bus.Lb = LAMP_GRN;
            B_YEL: bus.Lb = LAMP_YEL;
            FLASH: begin
                bus.La = blink_reg ? LAMP_YEL : LAMP_OFF;
                bus.Lb = blink_reg ? LAMP_RED : LAMP_OFF;
            end
            default: ;
        endcase
    end

    assign bus.phase     = state_reg;
    assign bus.phase_cnt = cnt_reg;

endmodule

// File: tb/tb_tl_ctrl_param.sv
// Bench for tl_ctrl_param: two instances (with and without all-red clearance) share
// stimulus; a reference model queues expected outputs and a monitor compares them.
module tb_tl_ctrl_param;

    localparam int GMIN = 3;
    localparam int GMAX = 6;
    localparam int YT   = 2;
    localparam int CW   = 4;

    localparam int S_AGRN = 0, S_AYEL = 1, S_ARAB = 2, S_BGRN = 3,
                   S_BYEL = 4, S_ARBA = 5, S_FLASH = 6;

    typedef struct packed {
        logic [1:0]    la;
        logic [1:0]    lb;
        logic [2:0]    ph;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk;
    logic reset_n;
    logic tick, ta, tb, fl;

    tl_ctrl_param_if #(.CNT_W(CW)) bus0 ();
    tl_ctrl_param_if #(.CNT_W(CW)) bus1 ();

    assign bus0.tick = tick;  assign bus0.Ta = ta;  assign bus0.Tb = tb;  assign bus0.flash = fl;
    assign bus1.tick = tick;  assign bus1.Ta = ta;  assign bus1.Tb = tb;  assign bus1.flash = fl;

    tl_ctrl_param #(.GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT), .ALLRED_T(1), .CNT_W(CW))
        dut (.clk(clk), .reset_n(reset_n), .bus(bus0));

    tl_ctrl_param #(.GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT), .ALLRED_T(0), .CNT_W(CW))
        dut_nr (.clk(clk), .reset_n(reset_n), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one entry per instance, allred clearance ticks per instance.
    int   m_st  [2];
    int   m_cnt [2];
    bit   m_blink [2];
    int   m_allred [2] = '{1, 0};
    exp_t q0[$];
    exp_t q1[$];

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;

    task automatic model_reset(input int i);
        m_st[i]    = S_ARBA;
        m_cnt[i]   = 0;
        m_blink[i] = 1'b0;
    endtask

    // Next phase by the traffic rules; counts are ticks already spent in the phase.
    function automatic int next_phase(input int st, input int cnt, input int allred);
        int spent = cnt + 1;
        case (st)
            S_AGRN: return ((spent >= GMIN && !ta) || spent >= GMAX) ? S_AYEL : S_AGRN;
            S_BGRN: return ((spent >= GMIN && !tb) || spent >= GMAX) ? S_BYEL : S_BGRN;
            S_AYEL: if (spent < YT) return S_AYEL;
                    else return fl ? S_FLASH : (allred > 0 ? S_ARAB : S_BGRN);
            S_BYEL: if (spent < YT) return S_BYEL;
                    else return fl ? S_FLASH : (allred > 0 ? S_ARBA : S_AGRN);
            S_ARAB: if (fl) return S_FLASH;
                    else return (spent >= allred) ? S_BGRN : S_ARAB;
            S_ARBA: if (fl) return S_FLASH;
                    else return (spent >= allred) ? S_AGRN : S_ARBA;
            default: return fl ? S_FLASH : S_ARBA;
        endcase
    endfunction

    task automatic model_step(input int i);
        int nxt;
        if (!tick) return;
        nxt = next_phase(m_st[i], m_cnt[i], m_allred[i]);
        if (nxt != m_st[i]) begin
            m_st[i]  = nxt;
            m_cnt[i] = 0;
            if (nxt == S_FLASH) m_blink[i] = 1'b1;
        end else begin
            m_cnt[i] = (m_cnt[i] < (1 << CW) - 1) ? m_cnt[i] + 1 : m_cnt[i];
            if (nxt == S_FLASH) m_blink[i] = ~m_blink[i];
        end
    endtask

    function automatic exp_t expected(input int i);
        exp_t e;
        e.la  = 2'b10;
        e.lb  = 2'b10;
        e.ph  = 3'(m_st[i]);
        e.cnt = CW'(m_cnt[i]);
        case (m_st[i])
            S_AGRN:  e.la = 2'b00;
            S_AYEL:  e.la = 2'b01;
            S_BGRN:  e.lb = 2'b00;
            S_BYEL:  e.lb = 2'b01;
            S_FLASH: begin
                e.la = m_blink[i] ? 2'b01 : 2'b11;
                e.lb = m_blink[i] ? 2'b10 : 2'b11;
            end
            default: ;
        endcase
        return e;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) model_reset(i);
            else          model_step(i);
        end
        q0.push_back(expected(0));
        q1.push_back(expected(1));
        cyc++;
    end

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got La=%b Lb=%b phase=%0d cnt=%0d, expected La=%b Lb=%b phase=%0d cnt=%0d",
                     name, cyc, got.la, got.lb, got.ph, got.cnt, want.la, want.lb, want.ph, want.cnt);
        end
    endtask

    function automatic exp_t sample(input int i);
        exp_t s;
        if (i == 0) s = {bus0.La, bus0.Lb, bus0.phase, bus0.phase_cnt};
        else        s = {bus1.La, bus1.Lb, bus1.phase, bus1.phase_cnt};
        return s;
    endfunction

    always @(negedge clk) begin
        if (q0.size() > 0) check("allred1", sample(0), q0.pop_front());
        if (q1.size() > 0) check("allred0", sample(1), q1.pop_front());
    end

    task automatic drive(input logic t, input logic a, input logic b, input logic f);
        @(posedge clk);
        #2;
        tick = t; ta = a; tb = b; fl = f;
    endtask

    task automatic wait_phase(input int i, input int ph, input string name);
        int n = 0;
        while (!(m_st[i] == ph && m_cnt[i] == 0) && n < 200) begin
            drive(1'b1, ta, tb, fl);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: phase %0d not reached within 200 cycles (model at %0d)", name, ph, m_st[i]);
        end
    endtask

    exp_t rst_want;

    initial begin
        reset_n = 1'b0;
        tick = 1'b1; ta = 1'b0; tb = 1'b1; fl = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Nominal cycle through both roads, tick every cycle.
        repeat (30) drive(1'b1, 1'b0, 1'b1, 1'b0);
        // Road A keeps demand, road B idle: A maxes out, B runs minimum.
        repeat (30) drive(1'b1, 1'b1, 1'b0, 1'b0);

        // Sparse tick, then no tick at all.
        for (int k = 0; k < 40; k++) drive((k % 4) == 3, 1'b0, 1'b1, 1'b0);
        repeat (50) drive(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);

        // Night flashing requested from the start of A green.
        ta = 1'b0; tb = 1'b1;
        wait_phase(0, S_AGRN, "reach_agrn");
        repeat (16) drive(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (10) drive(1'b1, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of B green, checked before the next edge.
        wait_phase(0, S_BGRN, "reach_bgrn");
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        rst_want = {2'b10, 2'b10, 3'd5, {CW{1'b0}}};
        check("async_rst_a1", sample(0), rst_want);
        check("async_rst_a0", sample(1), rst_want);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomised traffic, tick pacing and occasional flash requests.
        for (int k = 0; k < 3000; k++) begin
            logic f_new;
            f_new = ($urandom_range(0, 29) == 0) ? ~fl : fl;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1), f_new);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
